gshare_pht: RTL and testbench
=============================

Name: gshare_pht

Overview:
- Pattern history table and direction predictor; direct consumer of the BTB hit/target outputs in fetch.
- Combines BTB hit information with a gshare-indexed array of 2-bit saturating counters to produce the F-stage taken prediction and predicted next PC.
- Carries each prediction down to E and updates its counters there.
- Produces the E-stage taken-branch signal that gates BTB allocation, plus the mispredict/recovery PC.

Parameters:
- NUM_PHT_ENTRIES, 64: counter count; power of two; LOG2_PHT = $clog2(NUM_PHT_ENTRIES).
- GHR_BITS, 6: global history length; must satisfy GHR_BITS <= LOG2_PHT.

Ports:
- clk  input  1  clock; all state on posedge.
- reset_i  input  1  asynchronous, active-high reset.
- pc_i  input  32  F-stage PC.
- BTBtarget_i  input  32  F, BTB target (0 on miss).
- jumphit_i  input  1  F, BTB hit on a jump entry.
- branchhit_i  input  1  F, BTB hit on a branch entry.
- branchtaken_en_i  input  1  F, BTB hit; prediction may be taken.
- B_e_i  input  1  E, instruction in E is a conditional branch.
- taken_e_i  input  1  E, resolved branch outcome.
- target_e_i  input  32  E, resolved branch target.
- predict_taken_o  output  1  F, redirect fetch to pred_pc_o.
- pred_pc_o  output  32  F, predicted next PC.
- PHTincrement_o  output  1  E, B_e_i & taken_e_i; drives the BTB write condition.
- mispredict_o  output  1  E, branch direction mispredicted; flush F/D.
- recover_pc_o  output  32  E, correct next PC when mispredict_o is high.

Behaviour:
- F index: idx_f = pc_i[LOG2_PHT+1:2] XOR zero-extended GHR (GHR in the low bits).
- Counter read is asynchronous: ctr_f = PHT[idx_f].
- Prediction: predict_taken_o = branchtaken_en_i & (jumphit_i | (branchhit_i & ctr_f[1])).
- pred_pc_o = predict_taken_o ? BTBtarget_i : pc_i + 4.
- Counters: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Counter update: saturating; +1 if taken, -1 if not. 11 stays 11 on taken; 00 stays 00 on not-taken.
- Speculative GHR: on an F branch hit (branchhit_i & branchtaken_en_i), GHR <= {GHR[GHR_BITS-2:0], predicted direction}. Jumps and misses leave GHR unchanged.
- Pipeline: F→D→E registers carry valid, is_branch_hit, predicted direction, idx, GHR snapshot (pre-update) and pc. Fixed 2-cycle latency F to E; no stall input.
- E update: when B_e_i, PHT[idx_e] updates with taken_e_i.
  - Counter write is synchronous, so an F read of the same index in the same cycle sees the old value.
- mispredict_o = B_e_i & valid_e & (taken_e_i != pred_e). A BTB miss counts as predicted not-taken.
- recover_pc_o = taken_e_i ? target_e_i : pc_e + 4. Value is don't-care when mispredict_o = 0, but must still be driven.
- On mispredict:
  - GHR <= {ghr_e[GHR_BITS-2:0], taken_e_i}; this overrides any F-stage GHR update in the same cycle.
  - D and E pipeline valid bits clear on the next edge, so flushed instructions neither update the PHT nor raise mispredict_o.
- PHTincrement_o = B_e_i & taken_e_i & valid_e. Combinational, same cycle as E.
- Reset (asynchronous, any time including mid-update):
  - All counters 01; GHR 0.
  - All pipeline valid bits 0; pipeline pc/idx registers 0.
  - Outputs: predict_taken_o 0, pred_pc_o = pc_i + 4, PHTincrement_o 0, mispredict_o 0, recover_pc_o = 4.
  - No PHT write occurs in the reset cycle.
- Wrap-around: pc + 4 wraps modulo 2^32. Index XOR uses only the low LOG2_PHT bits.

Decomposition:
- Shared package holds:
  - counter-state constants: SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11;
  - the saturating-update function;
  - the F→E pipeline record typedef {valid, hit, pred, idx, ghr, pc}.
- One sub-module, pht_counter_array: async read port, sync write port with saturating update, async reset to WNT.

Test Plan:
- Reset, then pc_i = 0x100 with no BTB hit → predict_taken_o 0, pred_pc_o 0x104; assert reset mid-run and check all counters return to 01.
- BTB branch hit at 0x200 (target 0x300), counter 01 → not taken, pred_pc 0x204. Two E updates with taken_e_i = 1 at the same idx/GHR → counter 11. Next hit → pred_pc 0x300. Two further taken updates keep it at 11 (saturation).
- jumphit_i = 1, BTBtarget_i = 0x400 → predict_taken_o 1, pred_pc 0x400; GHR unchanged.
- Branch predicted not-taken resolves taken in E, target_e 0x500 → mispredict_o 1, recover_pc 0x500, PHTincrement_o 1. GHR equals snapshot shifted with 1. The next two cycles show no PHT update and no mispredict from flushed slots.
- Branch predicted taken at pc 0x600 resolves not-taken → mispredict_o 1, recover_pc 0x604, PHTincrement_o 0, counter decremented.
- Same-cycle E write and F read of the same index → F prediction uses the pre-write counter; the following cycle uses the updated counter.

Source files
------------

// File: rtl/gshare_pht_pkg.sv
// gshare_pht_pkg: shared definitions for the gshare direction predictor.
//   - 2-bit counter state encodings (SNT/WNT/WT/ST)
//   - ctr_update(): saturating counter update
//   - pipe_rec_t: F->D->E record carried alongside each fetched instruction
// The idx/ghr fields are sized to the largest supported configuration. Narrower
// configurations use the low bits and leave the upper bits at zero.
package gshare_pht_pkg;

    localparam logic [1:0] SNT = 2'b00;  // strong not-taken
    localparam logic [1:0] WNT = 2'b01;  // weak not-taken
    localparam logic [1:0] WT  = 2'b10;  // weak taken
    localparam logic [1:0] ST  = 2'b11;  // strong taken

    localparam int unsigned IDX_MAX_W = 16;
    localparam int unsigned GHR_MAX_W = 16;

    typedef struct packed {
        logic                 valid;
        logic                 hit;    // F saw a BTB branch hit with taken enabled
        logic                 pred;   // direction fetch actually followed
        logic [IDX_MAX_W-1:0] idx;    // PHT index used at F
        logic [GHR_MAX_W-1:0] ghr;    // GHR before the F-stage speculative shift
        logic [31:0]          pc;
    } pipe_rec_t;

    function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        if (taken) begin
            nxt = (ctr == ST) ? ST : ctr + 2'd1;
        end else begin
            nxt = (ctr == SNT) ? SNT : ctr - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/gshare_pht_counter_array.sv
// pht_counter_array: array of 2-bit saturating counters.
//   clk_i       clock
//   rst_i       asynchronous active-high reset; all counters -> WNT
//   rd_idx_i    asynchronous read index
//   rd_ctr_o    counter value at rd_idx_i (pre-write value on a same-cycle write)
//   wr_en_i     apply a saturating update at wr_idx_i on the next edge
//   wr_idx_i    update index
//   wr_taken_i  update direction (1: increment, 0: decrement)
module pht_counter_array
    import gshare_pht_pkg::*;
#(
    parameter int unsigned NumEntries = 64,
    parameter int unsigned IdxW       = $clog2(NumEntries)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [IdxW-1:0] rd_idx_i,
    output logic [1:0]      rd_ctr_o,
    input  logic            wr_en_i,
    input  logic [IdxW-1:0] wr_idx_i,
    input  logic            wr_taken_i
);

    logic [1:0] ctr_q [NumEntries];
    logic [1:0] wr_val_d;

    assign rd_ctr_o = ctr_q[rd_idx_i];

    always_comb begin
        wr_val_d = ctr_update(ctr_q[wr_idx_i], wr_taken_i);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(NumEntries); i++) begin
                ctr_q[i] <= WNT;
            end
        end else if (wr_en_i) begin
            ctr_q[wr_idx_i] <= wr_val_d;
        end
    end

endmodule

// File: rtl/gshare_pht.sv
// gshare_pht: gshare-indexed pattern history table and fetch direction predictor.
//   clk               clock, all state on posedge
//   reset_i           asynchronous active-high reset
//   pc_i              F-stage PC
//   BTBtarget_i       F, BTB target (0 on miss)
//   jumphit_i         F, BTB hit on a jump entry
//   branchhit_i       F, BTB hit on a branch entry
//   branchtaken_en_i  F, BTB hit; prediction may be taken
//   B_e_i             E, instruction in E is a conditional branch
//   taken_e_i         E, resolved branch outcome
//   target_e_i        E, resolved branch target
//   predict_taken_o   F, redirect fetch to pred_pc_o
//   pred_pc_o         F, predicted next PC
//   PHTincrement_o    E, valid taken conditional branch (BTB write condition)
//   mispredict_o      E, direction mispredicted; flush F/D
//   recover_pc_o      E, correct next PC when mispredict_o is high
module gshare_pht
    import gshare_pht_pkg::*;
#(
    parameter int unsigned NUM_PHT_ENTRIES = 64,
    parameter int unsigned GHR_BITS        = 6
) (
    input  logic        clk,
    input  logic        reset_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] BTBtarget_i,
    input  logic        jumphit_i,
    input  logic        branchhit_i,
    input  logic        branchtaken_en_i,
    input  logic        B_e_i,
    input  logic        taken_e_i,
    input  logic [31:0] target_e_i,
    output logic        predict_taken_o,
    output logic [31:0] pred_pc_o,
    output logic        PHTincrement_o,
    output logic        mispredict_o,
    output logic [31:0] recover_pc_o
);

    localparam int unsigned LOG2_PHT = $clog2(NUM_PHT_ENTRIES);

    if ((1 << LOG2_PHT) != NUM_PHT_ENTRIES) begin : g_bad_entries
        $error("NUM_PHT_ENTRIES must be a power of two");
    end
    if (GHR_BITS > LOG2_PHT || GHR_BITS < 2) begin : g_bad_ghr
        $error("GHR_BITS must be in [2, LOG2_PHT]");
    end
    if (LOG2_PHT > IDX_MAX_W || GHR_BITS > GHR_MAX_W) begin : g_bad_rec
        $error("configuration exceeds pipe_rec_t field widths");
    end

    typedef logic [LOG2_PHT-1:0] idx_t;

    logic [GHR_BITS-1:0] ghr_q, ghr_d;
    pipe_rec_t           pipe_d_q, pipe_d_d;
    pipe_rec_t           pipe_e_q, pipe_e_d;
    pipe_rec_t           rec_f;

    idx_t       idx_f;
    idx_t       idx_e;
    logic [1:0] ctr_f;
    logic       pred_raw;
    logic       f_branch_hit;
    logic       mispredict;
    logic       pht_we;

    // ---------------- F stage ----------------
    assign idx_f        = pc_i[LOG2_PHT+1:2] ^ idx_t'(ghr_q);
    assign f_branch_hit = branchhit_i & branchtaken_en_i;
    assign pred_raw     = branchtaken_en_i & (jumphit_i | (branchhit_i & ctr_f[1]));

    // Outputs are forced to their idle values while reset is asserted.
    assign predict_taken_o = pred_raw & ~reset_i;
    assign pred_pc_o       = predict_taken_o ? BTBtarget_i : pc_i + 32'd4;

    always_comb begin
        rec_f                     = '0;
        rec_f.valid               = 1'b1;
        rec_f.hit                 = f_branch_hit;
        rec_f.pred                = pred_raw;
        rec_f.idx[LOG2_PHT-1:0]   = idx_f;
        rec_f.ghr[GHR_BITS-1:0]   = ghr_q;
        rec_f.pc                  = pc_i;
    end

    // ---------------- E stage ----------------
    assign idx_e      = pipe_e_q.idx[LOG2_PHT-1:0];
    // A BTB miss leaves pred at 0, so it resolves as predicted not-taken.
    assign mispredict = B_e_i & pipe_e_q.valid & (taken_e_i != pipe_e_q.pred);
    assign pht_we     = B_e_i & pipe_e_q.valid & ~reset_i;

    assign mispredict_o   = mispredict;
    assign PHTincrement_o = B_e_i & taken_e_i & pipe_e_q.valid;
    assign recover_pc_o   = reset_i   ? 32'd4 :
                            taken_e_i ? target_e_i : pipe_e_q.pc + 32'd4;

    // ---------------- next state ----------------
    always_comb begin
        ghr_d = ghr_q;
        // Recovery rebuilds history from the E snapshot and wins over any F shift.
        if (mispredict) begin
            ghr_d = {pipe_e_q.ghr[GHR_BITS-2:0], taken_e_i};
        end else if (f_branch_hit) begin
            ghr_d = {ghr_q[GHR_BITS-2:0], pred_raw};
        end
    end

    always_comb begin
        pipe_d_d       = rec_f;
        pipe_d_d.valid = ~mispredict;
        pipe_e_d       = pipe_d_q;
        pipe_e_d.valid = pipe_d_q.valid & ~mispredict;
    end

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            ghr_q    <= '0;
            pipe_d_q <= '0;
            pipe_e_q <= '0;
        end else begin
            ghr_q    <= ghr_d;
            pipe_d_q <= pipe_d_d;
            pipe_e_q <= pipe_e_d;
        end
    end

    pht_counter_array #(
        .NumEntries (NUM_PHT_ENTRIES),
        .IdxW       (LOG2_PHT)
    ) u_pht (
        .clk_i      (clk),
        .rst_i      (reset_i),
        .rd_idx_i   (idx_f),
        .rd_ctr_o   (ctr_f),
        .wr_en_i    (pht_we),
        .wr_idx_i   (idx_e),
        .wr_taken_i (taken_e_i)
    );

    // hit and the upper/unused record bits are carried for debug only.
    logic unused_rec;
    assign unused_rec = ^{pipe_e_q.hit, pipe_e_q.idx, pipe_e_q.ghr};

endmodule

// File: tb/tb_gshare_pht.sv
// Directed, table-driven bench for gshare_pht with hand-computed expectations.
module tb_gshare_pht;

    logic        clk;
    logic        reset_i;
    logic [31:0] pc_i;
    logic [31:0] BTBtarget_i;
    logic        jumphit_i;
    logic        branchhit_i;
    logic        branchtaken_en_i;
    logic        B_e_i;
    logic        taken_e_i;
    logic [31:0] target_e_i;
    logic        predict_taken_o;
    logic [31:0] pred_pc_o;
    logic        PHTincrement_o;
    logic        mispredict_o;
    logic [31:0] recover_pc_o;

    int checks;
    int failures;

    gshare_pht #(
        .NUM_PHT_ENTRIES (64),
        .GHR_BITS        (6)
    ) dut (
        .clk              (clk),
        .reset_i          (reset_i),
        .pc_i             (pc_i),
        .BTBtarget_i      (BTBtarget_i),
        .jumphit_i        (jumphit_i),
        .branchhit_i      (branchhit_i),
        .branchtaken_en_i (branchtaken_en_i),
        .B_e_i            (B_e_i),
        .taken_e_i        (taken_e_i),
        .target_e_i       (target_e_i),
        .predict_taken_o  (predict_taken_o),
        .pred_pc_o        (pred_pc_o),
        .PHTincrement_o   (PHTincrement_o),
        .mispredict_o     (mispredict_o),
        .recover_pc_o     (recover_pc_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [31:0] pc;
        logic [31:0] tgt;
        logic        jh;
        logic        bh;
        logic        en;
        logic        be;
        logic        tk;
        logic [31:0] te;
        logic        pt;
        logic [31:0] ppc;
        logic        inc;
        logic        mis;
        logic [31:0] rec;
        logic        chk_st;  // check counter[0] and GHR after the edge
        logic [1:0]  ctr0;
        logic [5:0]  ghr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [31:0] pc, input logic [31:0] tgt,
                                input logic jh, input logic bh, input logic en,
                                input logic be, input logic tk, input logic [31:0] te,
                                input logic pt, input logic [31:0] ppc,
                                input logic inc, input logic mis, input logic [31:0] rec,
                                input logic chk_st, input logic [1:0] ctr0,
                                input logic [5:0] ghr);
        vec_t v;
        v.pc = pc; v.tgt = tgt; v.jh = jh; v.bh = bh; v.en = en;
        v.be = be; v.tk = tk; v.te = te;
        v.pt = pt; v.ppc = ppc; v.inc = inc; v.mis = mis; v.rec = rec;
        v.chk_st = chk_st; v.ctr0 = ctr0; v.ghr = ghr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic chk_all_wnt(input string name);
        int bad;
        bad = 0;
        for (int k = 0; k < 64; k++) begin
            if (dut.u_pht.ctr_q[k] !== 2'b01) bad++;
        end
        chk(name, 32'(bad), 32'd0);
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] tgt, input logic jh,
                         input logic bh, input logic en, input logic be, input logic tk,
                         input logic [31:0] te);
        pc_i = pc; BTBtarget_i = tgt; jumphit_i = jh; branchhit_i = bh;
        branchtaken_en_i = en; B_e_i = be; taken_e_i = tk; target_e_i = te;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset_i  = 1'b1;
        drive(32'h100, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

        // Cycle-by-cycle trace; an instruction fetched in row n reaches E in row n+2.
        //           pc       tgt     jh bh en be tk te        pt ppc      inc mis rec      st ctr ghr
        vecs.push_back(mk(32'h100, 32'h0,   0, 0, 0, 0, 0, 32'h0,   0, 32'h104, 0, 0, 32'h4,   0, 0, 0));
        vecs.push_back(mk(32'h200, 32'h300, 0, 1, 1, 0, 0, 32'h0,   0, 32'h204, 0, 0, 32'h4,   0, 0, 0));
        vecs.push_back(mk(32'h104, 32'h0,   0, 0, 0, 0, 0, 32'h0,   0, 32'h108, 0, 0, 32'h104, 0, 0, 0));
        vecs.push_back(mk(32'h108, 32'h0,   0, 0, 0, 1, 1, 32'h300, 0, 32'h10C, 1, 1, 32'h300, 0, 0, 0));
        vecs.push_back(mk(32'h10C, 32'h0,   0, 0, 0, 1, 1, 32'h300, 0, 32'h110, 0, 0, 32'h300, 0, 0, 0));
        vecs.push_back(mk(32'h110, 32'h0,   0, 0, 0, 1, 1, 32'h300, 0, 32'h114, 0, 0, 32'h300, 1, 2, 1));
        vecs.push_back(mk(32'h204, 32'h300, 0, 1, 1, 0, 0, 32'h0,   1, 32'h300, 0, 0, 32'h110, 0, 0, 0));
        vecs.push_back(mk(32'h20C, 32'h300, 0, 1, 1, 0, 0, 32'h0,   1, 32'h300, 0, 0, 32'h114, 0, 0, 0));
        vecs.push_back(mk(32'h300, 32'h0,   0, 0, 0, 1, 1, 32'h300, 0, 32'h304, 1, 0, 32'h300, 0, 0, 0));
        vecs.push_back(mk(32'h304, 32'h0,   0, 0, 0, 1, 1, 32'h300, 0, 32'h308, 1, 0, 32'h300, 0, 0, 0));
        vecs.push_back(mk(32'h308, 32'h0,   0, 0, 0, 0, 0, 32'h0,   0, 32'h30C, 0, 0, 32'h304, 1, 3, 7));
        vecs.push_back(mk(32'h700, 32'h400, 1, 0, 1, 0, 0, 32'h0,   1, 32'h400, 0, 0, 32'h308, 0, 0, 0));
        vecs.push_back(mk(32'h704, 32'h400, 1, 0, 0, 0, 0, 32'h0,   0, 32'h708, 0, 0, 32'h30C, 1, 3, 7));
        vecs.push_back(mk(32'h61C, 32'h680, 0, 1, 1, 0, 0, 32'h0,   1, 32'h680, 0, 0, 32'h704, 0, 0, 0));
        vecs.push_back(mk(32'h680, 32'h0,   0, 0, 0, 0, 0, 32'h0,   0, 32'h684, 0, 0, 32'h708, 0, 0, 0));
        vecs.push_back(mk(32'h63C, 32'h700, 0, 1, 1, 1, 0, 32'h0,   1, 32'h700, 0, 1, 32'h620, 1, 2, 14));
        vecs.push_back(mk(32'h238, 32'h300, 0, 1, 1, 1, 1, 32'h300, 1, 32'h300, 0, 0, 32'h300, 0, 0, 0));
        vecs.push_back(mk(32'h23C, 32'h0,   0, 0, 0, 1, 0, 32'h0,   0, 32'h240, 0, 0, 32'h640, 0, 0, 0));
        vecs.push_back(mk(32'h274, 32'h300, 0, 1, 1, 1, 0, 32'h0,   1, 32'h300, 0, 1, 32'h23C, 1, 1, 28));
        vecs.push_back(mk(32'h270, 32'h300, 0, 1, 1, 0, 0, 32'h0,   0, 32'h274, 0, 0, 32'h240, 0, 0, 0));
        vecs.push_back(mk(32'h800, 32'h0,   0, 0, 0, 0, 0, 32'h0,   0, 32'h804, 0, 0, 32'h278, 0, 0, 0));
        vecs.push_back(mk(32'h804, 32'h0,   0, 0, 0, 1, 0, 32'h0,   0, 32'h808, 0, 0, 32'h274, 1, 0, 56));

        // Power-on reset state.
        repeat (2) @(posedge clk);
        #1;
        chk_all_wnt("reset counters");
        chk("reset ghr", 32'(dut.ghr_q), 32'd0);
        chk("reset pred_pc", pred_pc_o, 32'h104);
        chk("reset recover_pc", recover_pc_o, 32'h4);
        @(negedge clk);
        reset_i = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].pc, vecs[i].tgt, vecs[i].jh, vecs[i].bh, vecs[i].en,
                  vecs[i].be, vecs[i].tk, vecs[i].te);
            #1;
            chk($sformatf("v%0d predict_taken", i), 32'(predict_taken_o), 32'(vecs[i].pt));
            chk($sformatf("v%0d pred_pc", i), pred_pc_o, vecs[i].ppc);
            chk($sformatf("v%0d PHTincrement", i), 32'(PHTincrement_o), 32'(vecs[i].inc));
            chk($sformatf("v%0d mispredict", i), 32'(mispredict_o), 32'(vecs[i].mis));
            chk($sformatf("v%0d recover_pc", i), recover_pc_o, vecs[i].rec);
            @(posedge clk);
            #1;
            if (vecs[i].chk_st) begin
                chk($sformatf("v%0d ctr0", i), 32'(dut.u_pht.ctr_q[0]), 32'(vecs[i].ctr0));
                chk($sformatf("v%0d ghr", i), 32'(dut.ghr_q), 32'(vecs[i].ghr));
            end
            @(negedge clk);
        end

        // Asynchronous reset mid-cycle with a jump hit and a valid-looking E update.
        drive(32'h800, 32'h400, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h900);
        #2;
        reset_i = 1'b1;
        #1;
        chk("midrst predict_taken", 32'(predict_taken_o), 32'd0);
        chk("midrst pred_pc", pred_pc_o, 32'h804);
        chk("midrst PHTincrement", 32'(PHTincrement_o), 32'd0);
        chk("midrst mispredict", 32'(mispredict_o), 32'd0);
        chk("midrst recover_pc", recover_pc_o, 32'h4);
        chk_all_wnt("midrst counters");
        chk("midrst ghr", 32'(dut.ghr_q), 32'd0);
        @(posedge clk);
        #1;
        chk_all_wnt("midrst no write on edge");
        @(negedge clk);
        reset_i = 1'b0;

        drive(32'h100, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        #1;
        chk("post-rst pred_pc", pred_pc_o, 32'h104);
        chk("post-rst predict_taken", 32'(predict_taken_o), 32'd0);
        drive(32'h100, 32'h400, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        #1;
        chk("post-rst jump taken", 32'(predict_taken_o), 32'd1);
        chk("post-rst jump pred_pc", pred_pc_o, 32'h400);
        drive(32'hFFFF_FFFC, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        #1;
        chk("wrap pred_pc", pred_pc_o, 32'h0);
        @(posedge clk);
        #1;
        chk("jump/miss ghr unchanged", 32'(dut.ghr_q), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
